// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared types and constants for the add_arbiter block
// Purpose: FSM state encoding, default geometry and the requester-id width helper.
// Ports: none (package).
package add_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int ADD_ARB_N_REQ = 4;
   localparam int ADD_ARB_WIDTH = 64;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/add_core.sv
// rtl/add_core.sv - combinational WIDTH-bit adder with carry in and carry out
// Purpose: {cout, sum} = a + b + cin, sum modulo 2^WIDTH.
// Ports: a, b   operand words
//        cin    carry in
//        sum    sum word
//        cout   carry out
module add_core #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin burst arbiter sharing one adder among N_REQ requesters
// Purpose: grants one requester at a time for a whole burst, adds a + b + carry per beat,
//          chains the carry across beats and registers the result with one cycle of latency.
// Ports: clk, rst                 clock, asynchronous active-high reset
//        req_valid/req_ready      per-requester beat handshake
//        req_a, req_b             packed operand words, requester i at [i*WIDTH +: WIDTH]
//        req_cin, req_last        carry in (first beat only), end of burst
//        rsp_valid/rsp_ready      result handshake
//        rsp_sum, rsp_cout        result word and carry out
//        rsp_id, rsp_last         owning requester, end of burst
module add_arbiter
   import add_arb_pkg::*;
#(
   parameter int N_REQ = ADD_ARB_N_REQ,
   parameter int WIDTH = ADD_ARB_WIDTH,
   localparam int IDW  = id_width(N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ-1:0]       req_cin,
   input  logic [N_REQ-1:0]       req_last,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH-1:0]   rsp_sum,
   output logic               rsp_cout,
   output logic [IDW-1:0]     rsp_id,
   output logic               rsp_last
);

   arb_state_t       state, state_nxt;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   grant;
   logic [IDW-1:0]   pick;
   logic             pick_ok;
   logic             first_beat;
   logic             carry;
   logic             out_free;
   logic             accept;
   logic [WIDTH-1:0] op_a, op_b, sum;
   logic             cin_sel, cout;

   // Round-robin pick: scanning offsets from high to low lets the lowest
   // offset from rr_ptr overwrite the others, so it wins.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
            pick    = IDW'((int'(rr_ptr) + k) % N_REQ);
            pick_ok = 1'b1;
         end
      end
   end

   // Operands of the granted requester; carry chains from the previous beat
   // except on the first beat of a burst.
   always_comb begin
      op_a    = req_a[int'(grant)*WIDTH +: WIDTH];
      op_b    = req_b[int'(grant)*WIDTH +: WIDTH];
      cin_sel = first_beat ? req_cin[grant] : carry;
   end

   add_core #(
      .WIDTH (WIDTH)
   ) u_add_core (
      .a    (op_a),
      .b    (op_b),
      .cin  (cin_sel),
      .sum  (sum),
      .cout (cout)
   );

   // Output register can take a new beat when empty or being drained now.
   assign out_free = !rsp_valid || rsp_ready;

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (pick_ok) state_nxt = BURST;
         end
         BURST: begin
            req_ready[grant] = out_free;
            accept           = req_valid[grant] && out_free;
            if (accept && req_last[grant]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         grant      <= '0;
         first_beat <= 1'b0;
         carry      <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_sum    <= '0;
         rsp_cout   <= 1'b0;
         rsp_id     <= '0;
         rsp_last   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_ok) begin
            grant      <= pick;
            first_beat <= 1'b1;
         end
         if (accept) begin
            carry      <= cout;
            first_beat <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_sum    <= sum;
            rsp_cout   <= cout;
            rsp_id     <= grant;
            rsp_last   <= req_last[grant];
            if (req_last[grant]) begin
               rr_ptr <= (grant == IDW'(N_REQ - 1)) ? '0 : grant + 1'b1;
            end
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - self-checking bench for add_arbiter
module tb_add_arbiter;

   localparam int N = 4;
   localparam int W = 64;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         last;
   } beat_t;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      int           id;
      logic         last;
   } res_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_ready, req_cin, req_last;
   logic [N*W-1:0] req_a, req_b;
   logic           rsp_valid, rsp_ready, rsp_cout, rsp_last;
   logic [W-1:0]   rsp_sum;
   logic [1:0]     rsp_id;

   add_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_last  (req_last),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_id    (rsp_id),
      .rsp_last  (rsp_last)
   );

   always #5 clk = ~clk;

   int         vectors = 0;
   int         miscompares = 0;
   beat_t      bq[N][$];
   res_t       m_q[$];
   res_t       seen[$];
   logic [N-1:0] hold;
   int         m_owner, m_rr;
   logic       m_first, m_carry;
   int         rdy_mode, stall_cnt;
   bit         hold_rand;

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] w;
      w = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) w = '1;
      return w;
   endfunction

   function automatic void clear_model();
      foreach (bq[i]) bq[i].delete();
      m_q.delete();
      seen.delete();
      hold      = '0;
      m_owner   = -1;
      m_rr      = 0;
      m_first   = 1'b0;
      m_carry   = 1'b0;
      stall_cnt = 0;
   endfunction

   function automatic bit drained();
      for (int i = 0; i < N; i++) if (bq[i].size() != 0) return 1'b0;
      return (m_q.size() == 0) && (m_owner < 0);
   endfunction

   function automatic void push_burst(input int r, input int len);
      beat_t bt;
      for (int j = 0; j < len; j++) begin
         bt.a = rnd_word(); bt.b = rnd_word();
         bt.cin = 1'($urandom); bt.last = (j == len - 1);
         bq[r].push_back(bt);
      end
   endfunction

   // One clock: drive, check against the reference, advance the reference.
   task automatic step();
      logic [N-1:0] exp_rdy;
      logic [W:0]   full;
      logic         c;
      res_t         r;
      @(negedge clk);
      if (hold_rand) for (int i = 0; i < N; i++) hold[i] = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
         if (bq[i].size() > 0 && !hold[i]) begin
            req_valid[i] = 1'b1;
            req_a[i*W +: W] = bq[i][0].a;
            req_b[i*W +: W] = bq[i][0].b;
            req_cin[i]  = bq[i][0].cin;
            req_last[i] = bq[i][0].last;
         end else begin
            req_valid[i] = 1'b0;
            req_a[i*W +: W] = rnd_word();
            req_b[i*W +: W] = rnd_word();
            req_cin[i]  = 1'($urandom);
            req_last[i] = 1'($urandom);
         end
      end
      case (rdy_mode)
         0: rsp_ready = 1'b1;
         1: rsp_ready = ($urandom_range(0, 2) != 0);
         default: begin
            rsp_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
         end
      endcase
      #1;
      exp_rdy = '0;
      if (m_owner >= 0 && (m_q.size() == 0 || rsp_ready)) exp_rdy[m_owner] = 1'b1;
      vectors++;
      if (req_ready !== exp_rdy) begin
         miscompares++;
         $display("FAIL req_ready @%0t: got %b want %b", $time, req_ready, exp_rdy);
      end
      vectors++;
      if (rsp_valid !== (m_q.size() > 0)) begin
         miscompares++;
         $display("FAIL rsp_valid @%0t: got %b want %0d", $time, rsp_valid, m_q.size());
      end
      if (m_q.size() > 0) begin
         vectors++;
         if (rsp_sum !== m_q[0].sum || rsp_cout !== m_q[0].cout ||
             rsp_id !== 2'(m_q[0].id) || rsp_last !== m_q[0].last) begin
            miscompares++;
            $display("FAIL rsp_data @%0t: got sum=%h cout=%b id=%0d last=%b want sum=%h cout=%b id=%0d last=%b",
                     $time, rsp_sum, rsp_cout, rsp_id, rsp_last,
                     m_q[0].sum, m_q[0].cout, m_q[0].id, m_q[0].last);
         end
      end
      if (rsp_valid === 1'b1 && rsp_ready) seen.push_back('{rsp_sum, rsp_cout, int'(rsp_id), rsp_last});
      if (m_q.size() > 0 && rsp_ready) void'(m_q.pop_front());
      if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) begin
               m_owner = (m_rr + k) % N;
               break;
            end
         end
         m_first = 1'b1;
      end else if (exp_rdy[m_owner] && req_valid[m_owner]) begin
         c    = m_first ? req_cin[m_owner] : m_carry;
         full = {1'b0, req_a[m_owner*W +: W]} + {1'b0, req_b[m_owner*W +: W]} + {{W{1'b0}}, c};
         r.sum = full[W-1:0]; r.cout = full[W]; r.id = m_owner; r.last = req_last[m_owner];
         m_q.push_back(r);
         m_carry = full[W];
         m_first = 1'b0;
         if (req_last[m_owner]) begin
            m_rr    = (m_owner + 1) % N;
            m_owner = -1;
         end
      end
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) void'(bq[i].pop_front());
   endtask

   task automatic run(input int budget);
      int n;
      n = 0;
      while (!drained() && n < budget) begin
         step();
         n++;
      end
      vectors++;
      if (!drained()) begin
         miscompares++;
         $display("FAIL drain_timeout: still busy after %0d cycles, want idle", n);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
      #1;
      vectors++;
      if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last, req_ready} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got valid=%b sum=%h cout=%b id=%0d last=%b ready=%b want all 0",
                  rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last, req_ready);
      end
      clear_model();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      seen.delete();
      rdy_mode = 0;
      bq[2].push_back('{64'd5, 64'd7, 1'b1, 1'b1});
      run(50);
      vectors++;
      if (seen.size() != 1 || seen[0].sum !== 64'd13 || seen[0].cout !== 1'b0 ||
          seen[0].id != 2 || seen[0].last !== 1'b1) begin
         miscompares++;
         $display("FAIL single_beat: got %0d results first sum=%0d id=%0d want 1 result sum=13 cout=0 id=2 last=1",
                  seen.size(), (seen.size() > 0) ? seen[0].sum : '0, (seen.size() > 0) ? seen[0].id : -1);
      end
   endtask

   task automatic test_carry_chain();
      seen.delete();
      bq[0].push_back('{'1, 64'd1, 1'b0, 1'b0});
      bq[0].push_back('{64'd0, 64'd0, 1'b1, 1'b1});
      run(50);
      vectors++;
      if (seen.size() != 2) begin
         miscompares++;
         $display("FAIL carry_chain_count: got %0d want 2", seen.size());
      end else begin
         vectors++;
         if (seen[0].sum !== 64'd0 || seen[0].cout !== 1'b1 || seen[0].last !== 1'b0) begin
            miscompares++;
            $display("FAIL carry_beat0: got sum=%h cout=%b want sum=0 cout=1", seen[0].sum, seen[0].cout);
         end
         vectors++;
         if (seen[1].sum !== 64'd1 || seen[1].cout !== 1'b0 || seen[1].last !== 1'b1) begin
            miscompares++;
            $display("FAIL carry_beat1: got sum=%h cout=%b want sum=1 cout=0", seen[1].sum, seen[1].cout);
         end
      end
   endtask

   task automatic test_round_robin();
      int exp_ids[5] = '{0, 1, 2, 3, 0};
      test_reset();
      push_burst(0, 1); push_burst(0, 1);
      push_burst(1, 1); push_burst(2, 1); push_burst(3, 1);
      run(100);
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (i >= seen.size() || seen[i].id != exp_ids[i]) begin
            miscompares++;
            $display("FAIL rr_order[%0d]: got %0d want %0d", i, (i < seen.size()) ? seen[i].id : -1, exp_ids[i]);
         end
      end
   endtask

   task automatic test_stall();
      seen.delete();
      rdy_mode = 2;
      push_burst(1, 5);
      repeat (3) step();
      stall_cnt = 3;
      run(100);
      rdy_mode = 0;
      vectors++;
      if (seen.size() != 5) begin
         miscompares++;
         $display("FAIL stall_count: got %0d beats want 5", seen.size());
      end
      for (int i = 0; i < seen.size(); i++) begin
         vectors++;
         if (seen[i].id != 1 || seen[i].last !== (i == 4)) begin
            miscompares++;
            $display("FAIL stall_beat[%0d]: got id=%0d last=%b want id=1 last=%b", i, seen[i].id, seen[i].last, i == 4);
         end
      end
   endtask

   task automatic test_lock();
      int exp_ids[4] = '{1, 1, 1, 3};
      test_reset();
      rdy_mode = 0;
      push_burst(1, 3);
      push_burst(3, 1);
      repeat (2) step();
      hold[1] = 1'b1;
      repeat (3) begin
         step();
         vectors++;
         if (req_ready[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_ready3: got %b want 0", req_ready[3]);
         end
      end
      hold[1] = 1'b0;
      run(100);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (i >= seen.size() || seen[i].id != exp_ids[i]) begin
            miscompares++;
            $display("FAIL lock_order[%0d]: got %0d want %0d", i, (i < seen.size()) ? seen[i].id : -1, exp_ids[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      test_reset();
      rdy_mode = 0;
      push_burst(2, 4);
      repeat (3) step();
      vectors++;
      if (rsp_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_setup_valid: got %b want 1", rsp_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (rsp_valid !== 1'b0 || req_ready !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_async: got valid=%b ready=%b want 0/0000", rsp_valid, req_ready);
      end
      clear_model();
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      bq[0].push_back('{64'd1, 64'd1, 1'b1, 1'b1});
      push_burst(2, 1);
      run(100);
      vectors++;
      if (seen.size() != 2 || seen[0].id != 0 || seen[0].sum !== 64'd3 ||
          seen[0].cout !== 1'b0 || seen[1].id != 2) begin
         miscompares++;
         $display("FAIL after_reset: got %0d results first id=%0d sum=%0d want 2 results first id=0 sum=3",
                  seen.size(), (seen.size() > 0) ? seen[0].id : -1, (seen.size() > 0) ? seen[0].sum : '0);
      end
   endtask

   task automatic test_random();
      int total;
      test_reset();
      total = 0;
      rdy_mode = 1;
      hold_rand = 1'b1;
      for (int k = 0; k < 30; k++) begin
         int r, len;
         r   = $urandom_range(0, N - 1);
         len = $urandom_range(1, 4);
         push_burst(r, len);
         total += len;
      end
      run(4000);
      hold_rand = 1'b0;
      hold = '0;
      rdy_mode = 0;
      vectors++;
      if (seen.size() != total) begin
         miscompares++;
         $display("FAIL random_count: got %0d beats want %0d", seen.size(), total);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_last = '0;
      rsp_ready = 1'b1;
      hold_rand = 1'b0;
      rdy_mode  = 0;
      clear_model();
      test_reset();
      test_single();
      test_carry_chain();
      test_round_robin();
      test_stall();
      test_lock();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
